// File: rtl/mips_uart_pkg.sv
// Shared definitions for the MIPS UART transmitter and receiver:
// FSM state encodings, default line-rate constants and small sizing helpers.
package mips_uart_pkg;

    // 2-bit FSM state encodings, common to TX and RX
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    // Default line configuration
    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_SB_TICK    = 16;
    localparam int DEF_BAUD_DIV   = 326;

    // Counter width able to hold 0..max_count-1, never narrower than one bit
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

    // Larger of two sizing values
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mips_uart_baud_gen.sv
// Baud tick generator: one-cycle tick every BAUD_DIV clocks while enabled.
// Held at zero while disabled, so the first tick lands exactly BAUD_DIV
// clocks after enable rises.
module mips_uart_baud_gen
    import mips_uart_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int               CNT_W    = cnt_width(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next divider count: clear while disabled, wrap after the last clock of a tick period
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mips_uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, stop period of
// SB_TICK baud ticks. o_tx_done is high exactly while the FSM sits in IDLE, so
// a requester holding i_tx_start sees done fall after acceptance and rise at
// the end of every frame.
module mips_uart_tx
    import mips_uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int BAUD_DIV   = DEF_BAUD_DIV
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx,
    output logic                 o_tx_done
);

    localparam int                TICK_W   = cnt_width(max2(OVERSAMPLE, SB_TICK));
    localparam int                BIT_W    = $clog2(DATA_BITS) + 1;
    localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic [1:0]           state_q,    state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q,    shreg_d;
    logic                 tx_q,       tx_d;
    logic                 tick;

    // The divider runs only during a frame; IDLE keeps it parked at zero
    mips_uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q != ST_IDLE),
        .tick   (tick)
    );

    // Frame sequencing: accept in IDLE, then count ticks per bit and bits per byte
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (i_tx_start) begin
                    shreg_d = i_tx_data;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tick_cnt_q == OS_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == OS_LAST) begin
                        tick_cnt_d = '0;
                        shreg_d    = shreg_q >> 1;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == SB_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, derived from next state so the pin register changes with the state
    always_comb begin
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State, counters, shift register and registered serial line
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
        end
    end

    assign o_tx      = tx_q;
    assign o_tx_done = (state_q == ST_IDLE);

endmodule

// File: tb/tb_mips_uart_tx.sv
// Testbench for mips_uart_tx with BAUD_DIV=4, OVERSAMPLE=16, SB_TICK=16:
// 64 clocks per bit, 640 clocks per frame.
`timescale 1ns/1ps
module tb_mips_uart_tx;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int SB_TICK    = 16;
    localparam int BAUD_DIV   = 4;
    localparam int CPB        = OVERSAMPLE * BAUD_DIV;
    localparam int FRAME      = ((1 + DATA_BITS) * OVERSAMPLE + SB_TICK) * BAUD_DIV;
    localparam int NSLOT      = DATA_BITS + 2;
    localparam int BUF        = 2 * FRAME + 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_tx_start;
    logic [7:0] i_tx_data;
    logic       o_tx;
    logic       o_tx_done;

    int total = 0;
    int bad   = 0;

    logic line_s [BUF];
    logic done_s [BUF];

    // Independent line decoder used by the handshake scenario
    logic       mon_en = 1'b0;
    logic       mon_busy = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    logic [7:0] mon_q [$];

    always #5 clk = ~clk;

    mips_uart_tx #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE),
        .SB_TICK    (SB_TICK),
        .BAUD_DIV   (BAUD_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_tx_start (i_tx_start),
        .i_tx_data  (i_tx_data),
        .o_tx       (o_tx),
        .o_tx_done  (o_tx_done)
    );

    // Decode frames by sampling mid-bit after a falling start edge
    always @(negedge clk) begin
        if (!mon_en) begin
            mon_busy <= 1'b0;
        end else if (!mon_busy) begin
            if (o_tx === 1'b0) begin
                mon_busy <= 1'b1;
                mon_cnt  <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt % CPB == CPB / 2) begin
                if (mon_cnt > CPB && mon_cnt < CPB * (1 + DATA_BITS)) begin
                    mon_byte <= {o_tx, mon_byte[7:1]};
                end else if (mon_cnt > CPB * (1 + DATA_BITS)) begin
                    mon_q.push_back(mon_byte);
                    mon_busy <= 1'b0;
                end
            end
        end
    end

    // Reference line level k clocks after acceptance of byte 'data'
    function automatic logic exp_level(input logic [7:0] data, input int k);
        int slot;
        if (k < CPB) return 1'b0;
        if (k < CPB * (1 + DATA_BITS)) begin
            slot = (k - CPB) / CPB;
            return data[slot[2:0]];
        end
        return 1'b1;
    endfunction

    // Number of recorded samples in one bit slot that differ from the reference
    function automatic int slot_errs(input int base, input logic [7:0] data, input int slot);
        int n = 0;
        for (int j = 0; j < CPB; j++) begin
            if (line_s[base + slot * CPB + j] !== exp_level(data, slot * CPB + j)) n++;
        end
        return n;
    endfunction

    // Number of recorded samples over a whole frame that differ from the reference
    function automatic int frame_errs(input int base, input logic [7:0] data);
        int n = 0;
        for (int s = 0; s < NSLOT; s++) n += slot_errs(base, data, s);
        return n;
    endfunction

    // Length of the run of done=0 samples starting at base
    function automatic int done_low_len(input int base);
        int n = 0;
        while (base + n < BUF && done_s[base + n] === 1'b0) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one frame and record line/done for nsamp cycles after acceptance.
    // kind: 1 = change data to pval, 2 = one-cycle start pulse, 3 = one-cycle reset, at sample pk.
    task automatic capture(input logic [7:0] data, input bit hold, input int nsamp,
                           input int pk, input int kind, input logic [7:0] pval);
        i_tx_data  = data;
        i_tx_start = 1'b1;
        step();
        if (!hold) i_tx_start = 1'b0;
        for (int k = 0; k < nsamp; k++) begin
            if (k == pk) begin
                case (kind)
                    1: i_tx_data = pval;
                    2: i_tx_start = 1'b1;
                    3: reset = 1'b1;
                    default: ;
                endcase
            end else if (k == pk + 1) begin
                if (kind == 2) i_tx_start = 1'b0;
                if (kind == 3) reset = 1'b0;
            end
            if (hold && k == FRAME + 1) i_tx_start = 1'b0;
            line_s[k] = o_tx;
            done_s[k] = o_tx_done;
            step();
        end
    endtask

    task automatic test_reset();
        int idle_errs = 0;
        reset      = 1'b1;
        i_tx_start = 1'b0;
        i_tx_data  = 8'h00;
        step();
        step();
        reset = 1'b0;
        total++;
        if (o_tx !== 1'b1) begin
            bad++;
            $display("FAIL reset_tx: got %b expected 1", o_tx);
        end
        total++;
        if (o_tx_done !== 1'b1) begin
            bad++;
            $display("FAIL reset_done: got %b expected 1", o_tx_done);
        end
        for (int i = 0; i < 20; i++) begin
            i_tx_data = 8'($urandom);
            step();
            if (o_tx !== 1'b1 || o_tx_done !== 1'b1) idle_errs++;
        end
        total++;
        if (idle_errs !== 0) begin
            bad++;
            $display("FAIL idle_hold: %0d cycles not idle, expected 0", idle_errs);
        end
    endtask

    task automatic test_a5();
        int e;
        capture(8'hA5, 1'b0, FRAME + 1, -5, 0, 8'h00);
        for (int s = 0; s < NSLOT; s++) begin
            e = slot_errs(0, 8'hA5, s);
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL a5_slot%0d: %0d of %0d samples wrong, mid level %b expected %b",
                         s, e, CPB, line_s[s * CPB + CPB / 2], exp_level(8'hA5, s * CPB));
            end
        end
        total++;
        if (done_low_len(0) !== FRAME) begin
            bad++;
            $display("FAIL a5_done_low: got %0d expected %0d", done_low_len(0), FRAME);
        end
        total++;
        if (done_s[FRAME] !== 1'b1) begin
            bad++;
            $display("FAIL a5_done_end: got %b expected 1", done_s[FRAME]);
        end
    endtask

    task automatic test_random_bytes();
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            capture(d, 1'b0, FRAME + 1, -5, 0, 8'h00);
            total++;
            if (frame_errs(0, d) !== 0) begin
                bad++;
                $display("FAIL rand_frame_%02h: %0d samples wrong, expected 0", d, frame_errs(0, d));
            end
            total++;
            if (done_low_len(0) !== FRAME) begin
                bad++;
                $display("FAIL rand_len_%02h: got %0d expected %0d", d, done_low_len(0), FRAME);
            end
        end
    endtask

    task automatic test_back_to_back();
        capture(8'h00, 1'b1, 2 * FRAME + 2, 0, 1, 8'hFF);
        total++;
        if (frame_errs(0, 8'h00) !== 0) begin
            bad++;
            $display("FAIL b2b_frame00: %0d samples wrong, expected 0", frame_errs(0, 8'h00));
        end
        total++;
        if (done_low_len(0) !== FRAME) begin
            bad++;
            $display("FAIL b2b_len1: got %0d expected %0d", done_low_len(0), FRAME);
        end
        total++;
        if (done_s[FRAME] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done_gap: got %b expected 1", done_s[FRAME]);
        end
        total++;
        if (done_low_len(FRAME + 1) !== FRAME) begin
            bad++;
            $display("FAIL b2b_len2: got %0d expected %0d", done_low_len(FRAME + 1), FRAME);
        end
        total++;
        if (frame_errs(FRAME + 1, 8'hFF) !== 0) begin
            bad++;
            $display("FAIL b2b_frameFF: %0d samples wrong, expected 0", frame_errs(FRAME + 1, 8'hFF));
        end
        total++;
        if (done_s[2 * FRAME + 1] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done_end: got %b expected 1", done_s[2 * FRAME + 1]);
        end
    endtask

    task automatic test_data_change();
        capture(8'h3C, 1'b0, FRAME + 1, 100, 1, 8'hC3);
        total++;
        if (frame_errs(0, 8'h3C) !== 0) begin
            bad++;
            $display("FAIL data_change: %0d samples differ from 0x3C frame, expected 0", frame_errs(0, 8'h3C));
        end
        total++;
        if (done_low_len(0) !== FRAME) begin
            bad++;
            $display("FAIL data_change_len: got %0d expected %0d", done_low_len(0), FRAME);
        end
    endtask

    task automatic test_ignored_start();
        logic [7:0] d;
        int extra = 0;
        d = 8'($urandom);
        capture(d, 1'b0, FRAME + 1, 200, 2, 8'h00);
        total++;
        if (frame_errs(0, d) !== 0) begin
            bad++;
            $display("FAIL ign_start_frame: %0d samples wrong, expected 0", frame_errs(0, d));
        end
        for (int i = 0; i < 100; i++) begin
            if (o_tx !== 1'b1 || o_tx_done !== 1'b1) extra++;
            step();
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL ign_start_no_second: %0d busy cycles, expected 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] d;
        int idle_errs = 0;
        d = 8'($urandom);
        capture(d, 1'b0, FRAME + 1, 300, 3, 8'h00);
        total++;
        if (done_s[300] !== 1'b0) begin
            bad++;
            $display("FAIL abort_pre_done: got %b expected 0", done_s[300]);
        end
        total++;
        if (line_s[301] !== 1'b1) begin
            bad++;
            $display("FAIL abort_tx: got %b expected 1", line_s[301]);
        end
        total++;
        if (done_s[301] !== 1'b1) begin
            bad++;
            $display("FAIL abort_done: got %b expected 1", done_s[301]);
        end
        for (int k = 302; k <= FRAME; k++) begin
            if (line_s[k] !== 1'b1 || done_s[k] !== 1'b1) idle_errs++;
        end
        total++;
        if (idle_errs !== 0) begin
            bad++;
            $display("FAIL abort_idle: %0d busy samples, expected 0", idle_errs);
        end
        d = 8'($urandom);
        capture(d, 1'b0, FRAME + 1, -5, 0, 8'h00);
        total++;
        if (frame_errs(0, d) !== 0) begin
            bad++;
            $display("FAIL abort_next_frame: %0d samples wrong, expected 0", frame_errs(0, d));
        end
        total++;
        if (done_low_len(0) !== FRAME) begin
            bad++;
            $display("FAIL abort_next_len: got %0d expected %0d", done_low_len(0), FRAME);
        end
    endtask

    task automatic test_handshake();
        logic [31:0] word = 32'h12345678;
        logic [7:0]  exp_b [4];
        int          n;
        mon_q.delete();
        mon_en = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            exp_b[i]   = word[31 - 8 * i -: 8];
            i_tx_data  = exp_b[i];
            i_tx_start = 1'b1;
            n = 0;
            while (o_tx_done === 1'b1 && n < 10) begin
                step();
                n++;
            end
            i_tx_start = 1'b0;
            total++;
            if (o_tx_done !== 1'b0) begin
                bad++;
                $display("FAIL hs_accept%0d: done %b expected 0", i, o_tx_done);
            end
            n = 0;
            while (o_tx_done !== 1'b1 && n < FRAME + 20) begin
                step();
                n++;
            end
            total++;
            if (o_tx_done !== 1'b1) begin
                bad++;
                $display("FAIL hs_done%0d: done %b expected 1", i, o_tx_done);
            end
        end
        for (int i = 0; i < 10; i++) step();
        mon_en = 1'b0;
        total++;
        if (mon_q.size() !== 4) begin
            bad++;
            $display("FAIL hs_count: got %0d bytes expected 4", mon_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= mon_q.size()) begin
                bad++;
                $display("FAIL hs_byte%0d: missing, expected %02h", i, exp_b[i]);
            end else if (mon_q[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL hs_byte%0d: got %02h expected %02h", i, mon_q[i], exp_b[i]);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        i_tx_start = 1'b0;
        i_tx_data  = 8'h00;
        test_reset();
        test_a5();
        test_random_bytes();
        test_back_to_back();
        test_data_change();
        test_ignored_start();
        test_reset_abort();
        test_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
